// File: rtl/pwm_rgb_driver_if.sv
// Signal bundle between the colour sequencer and the RGB PWM driver.
// The master drives enable and duty requests; the slave returns the LED drive and status.
interface pwm_rgb_driver_if;
   logic       en;
   logic [7:0] R_time_in;
   logic [7:0] G_time_in;
   logic [7:0] B_time_in;
   logic       pwm_r;
   logic       pwm_g;
   logic       pwm_b;
   logic       period_end;
   logic       fade_busy;

   modport master (
      output en, R_time_in, G_time_in, B_time_in,
      input  pwm_r, pwm_g, pwm_b, period_end, fade_busy
   );

   modport slave (
      input  en, R_time_in, G_time_in, B_time_in,
      output pwm_r, pwm_g, pwm_b, period_end, fade_busy
   );
endinterface

// File: rtl/pwm_rgb_driver.sv
// Three-channel 255-cycle PWM driver for the RGB LED, running on the divided tick clock.
// Duty requests are captured once per period and optionally faded in FADE_STEP increments.
module pwm_rgb_driver #(
   parameter int FADE_STEP  = 8,
   parameter bit ACTIVE_LOW = 1'b1
) (
   input logic             clk_div,
   input logic             rst,
   pwm_rgb_driver_if.slave bus
);

   localparam logic       OFF_LVL = ACTIVE_LOW;
   localparam logic       ON_LVL  = ~ACTIVE_LOW;
   localparam logic [8:0] STEP9   = 9'(FADE_STEP);
   localparam logic [7:0] LAST_CNT = 8'd254;

   typedef enum logic [1:0] {
      S_OFF,
      S_RUN,
      S_FADE
   } state_t;

   state_t          state_q, state_d;
   logic [7:0]      cnt_q, cnt_d;
   logic [2:0][7:0] cur_q, cur_d;
   logic [2:0][7:0] tgt_q, tgt_d;
   logic [2:0]      pwm_q, pwm_d;
   logic            periodEnd_q, periodEnd_d;
   logic            fadeBusy_q, fadeBusy_d;
   logic [2:0][7:0] dutyIn;
   logic            wrapEdge;

   assign dutyIn   = {bus.B_time_in, bus.G_time_in, bus.R_time_in};
   assign wrapEdge = (cnt_q == LAST_CNT);

   // One fade step in 9-bit space: land exactly on the target once it is within reach.
   function automatic logic [7:0] stepToward(input logic [7:0] cur, input logic [7:0] tgt);
      logic [8:0] c9;
      logic [8:0] t9;
      logic [8:0] nxt;
      c9 = {1'b0, cur};
      t9 = {1'b0, tgt};
      if (t9 >= c9) begin
         nxt = ((t9 - c9) <= STEP9) ? t9 : (c9 + STEP9);
      end else begin
         nxt = ((c9 - t9) <= STEP9) ? t9 : (c9 - STEP9);
      end
      return nxt[7:0];
   endfunction

   // State, counter and duty registers; reset drops the LED to its off level at once.
   always_ff @(posedge clk_div or posedge rst) begin
      if (rst) begin
         state_q     <= S_OFF;
         cnt_q       <= 8'd0;
         cur_q       <= '0;
         tgt_q       <= '0;
         pwm_q       <= {3{OFF_LVL}};
         periodEnd_q <= 1'b0;
         fadeBusy_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         cur_q       <= cur_d;
         tgt_q       <= tgt_d;
         pwm_q       <= pwm_d;
         periodEnd_q <= periodEnd_d;
         fadeBusy_q  <= fadeBusy_d;
      end
   end

   // Next-state logic. Requests are only looked at on the wrap edge so a period is never split;
   // disabling parks the counter but keeps cur/tgt so the colour resumes on re-enable.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      cur_d       = cur_q;
      tgt_d       = tgt_q;
      pwm_d       = {3{OFF_LVL}};
      periodEnd_d = 1'b0;

      if (!bus.en) begin
         state_d = S_OFF;
         cnt_d   = 8'd0;
      end else begin
         case (state_q)
            S_OFF: begin
               state_d = S_RUN;
               cnt_d   = 8'd0;
            end
            S_RUN, S_FADE: begin
               for (int i = 0; i < 3; i++) begin
                  pwm_d[i] = (cnt_q < cur_q[i]) ? ON_LVL : OFF_LVL;
               end
               periodEnd_d = wrapEdge;
               cnt_d       = wrapEdge ? 8'd0 : cnt_q + 8'd1;
               if (wrapEdge) begin
                  tgt_d = dutyIn;
                  if (FADE_STEP == 0) begin
                     cur_d = dutyIn;
                  end else begin
                     for (int i = 0; i < 3; i++) begin
                        cur_d[i] = stepToward(cur_q[i], tgt_q[i]);
                     end
                  end
                  state_d = (cur_d == dutyIn) ? S_RUN : S_FADE;
               end
            end
            default: begin
               state_d = S_OFF;
               cnt_d   = 8'd0;
            end
         endcase
      end

      fadeBusy_d = (state_d == S_FADE);
   end

   assign bus.pwm_r      = pwm_q[0];
   assign bus.pwm_g      = pwm_q[1];
   assign bus.pwm_b      = pwm_q[2];
   assign bus.period_end = periodEnd_q;
   assign bus.fade_busy  = fadeBusy_q;

endmodule
